// File: rtl/piso_shift_tx.sv
// piso_shift_tx: parallel-in / serial-out transmitter.
// A word is accepted through a LOAD/READY handshake and sent one bit per clock
// on OUT. OUT_EN marks frame bits. DONE pulses for one cycle after the last bit.
// Back-to-back frames are supported by accepting a new LOAD on the last-bit cycle.
module piso_shift_tx #(
    parameter int   WIDTH      = 4,
    parameter bit   MSB_FIRST  = 1'b1,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [WIDTH-1:0] DIN,
    input  logic             LOAD,
    output logic             READY,
    output logic             OUT,
    output logic             OUT_EN,
    output logic             DONE
);

    localparam int             CW     = $clog2(WIDTH);
    localparam logic [CW-1:0]  C_LAST = CW'(WIDTH - 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_shift;
    logic [CW-1:0]    r_count;
    logic             r_out;
    logic             r_out_en;
    logic             r_done;
    logic             w_ready;
    logic             w_accept;

    // First bit of a freshly captured word.
    function automatic logic first_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    // Bit that follows the one currently on OUT. The register is kept aligned
    // so that the current bit always sits at the first-bit position.
    function automatic logic next_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-2] : w[1];
    endfunction

    // Advance the shift register by one bit in the transmit direction.
    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? (w << 1) : (w >> 1);
    endfunction

    // READY: idle, or the last bit of the current frame is on OUT.
    always_comb begin
        w_ready  = (r_state == S_IDLE) || (r_count == C_LAST);
        w_accept = LOAD && w_ready;
    end

    // Frame FSM with registered serial outputs.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state  <= S_IDLE;
            r_shift  <= '0;
            r_count  <= '0;
            r_out    <= IDLE_LEVEL;
            r_out_en <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_state  <= S_SHIFT;
                        r_shift  <= DIN;
                        r_out    <= first_bit(DIN);
                        r_out_en <= 1'b1;
                        r_count  <= '0;
                    end
                end
                S_SHIFT: begin
                    if (r_count != C_LAST) begin
                        r_shift <= advance(r_shift);
                        r_out   <= next_bit(r_shift);
                        r_count <= r_count + CW'(1);
                    end else begin
                        r_done <= 1'b1;
                        if (w_accept) begin
                            // Gapless restart: new frame's first bit follows immediately.
                            r_shift  <= DIN;
                            r_out    <= first_bit(DIN);
                            r_out_en <= 1'b1;
                            r_count  <= '0;
                        end else begin
                            r_state  <= S_IDLE;
                            r_out    <= IDLE_LEVEL;
                            r_out_en <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_out    <= IDLE_LEVEL;
                    r_out_en <= 1'b0;
                end
            endcase
        end
    end

    assign READY  = w_ready;
    assign OUT    = r_out;
    assign OUT_EN = r_out_en;
    assign DONE   = r_done;

endmodule

// File: tb/tb_piso_shift_tx.sv
// Testbench for piso_shift_tx: one MSB-first and one LSB-first instance,
// per-cycle vector table plus a bit scoreboard fed at stimulus time.
module tb_piso_shift_tx;

    logic       clk;
    logic       rst;
    logic       load_m, load_l;
    logic [3:0] din_m, din_l;
    logic       rdy_m, out_m, en_m, done_m;
    logic       rdy_l, out_l, en_l, done_l;
    logic [3:0] sipo;

    int tests = 0;
    int fails = 0;

    logic q_m[$];
    logic q_l[$];

    typedef struct {
        bit         lsb;
        logic       load;
        logic [3:0] din;
        bit         acc;
        logic       e_out;
        logic       e_en;
        logic       e_done;
        logic       e_rdy;
        bit         sipo_chk;
        logic [3:0] e_sipo;
    } vec_t;

    vec_t tbl[$];

    piso_shift_tx #(.WIDTH(4), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut_m (
        .CLK(clk), .RESET(rst), .DIN(din_m), .LOAD(load_m),
        .READY(rdy_m), .OUT(out_m), .OUT_EN(en_m), .DONE(done_m)
    );

    piso_shift_tx #(.WIDTH(4), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut_l (
        .CLK(clk), .RESET(rst), .DIN(din_l), .LOAD(load_l),
        .READY(rdy_l), .OUT(out_l), .OUT_EN(en_l), .DONE(done_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Receiver model: left-shifting SIPO on the same clock.
    always @(posedge clk) sipo <= {sipo[2:0], out_m};

    task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Scoreboard monitors: every OUT_EN cycle consumes one expected bit.
    always begin
        @(posedge clk);
        #2;
        if (en_m === 1'b1) begin
            if (q_m.size() == 0) chk("sb_m_underflow", 4'd1, 4'd0);
            else                 chk("sb_m_bit", {3'b0, out_m}, {3'b0, q_m.pop_front()});
        end
        if (en_l === 1'b1) begin
            if (q_l.size() == 0) chk("sb_l_underflow", 4'd1, 4'd0);
            else                 chk("sb_l_bit", {3'b0, out_l}, {3'b0, q_l.pop_front()});
        end
    end

    function automatic vec_t mk(bit lsb, logic ld, logic [3:0] d, bit acc,
                                logic eo, logic ee, logic ed, logic er);
        vec_t v;
        v.lsb = lsb; v.load = ld; v.din = d; v.acc = acc;
        v.e_out = eo; v.e_en = ee; v.e_done = ed; v.e_rdy = er;
        v.sipo_chk = 1'b0; v.e_sipo = 4'h0;
        return v;
    endfunction

    // Drive one cycle of inputs, take the edge, then check the selected DUT.
    task automatic apply_row(input vec_t v);
        if (v.lsb) begin
            load_l = v.load; din_l = v.din; load_m = 1'b0;
            if (v.acc) for (int i = 0; i < 4; i++) q_l.push_back(v.din[i]);
        end else begin
            load_m = v.load; din_m = v.din; load_l = 1'b0;
            if (v.acc) for (int i = 3; i >= 0; i--) q_m.push_back(v.din[i]);
        end
        @(posedge clk);
        #1;
        if (v.lsb) begin
            chk("l_out",   {3'b0, out_l},  {3'b0, v.e_out});
            chk("l_en",    {3'b0, en_l},   {3'b0, v.e_en});
            chk("l_done",  {3'b0, done_l}, {3'b0, v.e_done});
            chk("l_ready", {3'b0, rdy_l},  {3'b0, v.e_rdy});
        end else begin
            chk("m_out",   {3'b0, out_m},  {3'b0, v.e_out});
            chk("m_en",    {3'b0, en_m},   {3'b0, v.e_en});
            chk("m_done",  {3'b0, done_m}, {3'b0, v.e_done});
            chk("m_ready", {3'b0, rdy_m},  {3'b0, v.e_rdy});
        end
        if (v.sipo_chk) chk("sipo_q", sipo, v.e_sipo);
    endtask

    initial begin
        vec_t v;
        rst = 1'b1; load_m = 1'b0; load_l = 1'b0; din_m = 4'h0; din_l = 4'h0;

        // Idle after reset.
        for (int i = 0; i < 10; i++) tbl.push_back(mk(0, 0, 4'h0, 0, 0, 0, 0, 1));
        // Single MSB-first frame 1011, receiver reads it back on the DONE cycle.
        tbl.push_back(mk(0, 1, 4'b1011, 1, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 4'b0000, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 4'b0000, 0, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 4'b0000, 0, 1, 1, 0, 1));
        v = mk(0, 0, 4'b0000, 0, 0, 0, 1, 1); v.sipo_chk = 1'b1; v.e_sipo = 4'b1011;
        tbl.push_back(v);
        tbl.push_back(mk(0, 0, 4'b0000, 0, 0, 0, 0, 1));
        // LSB-first frame 1000.
        tbl.push_back(mk(1, 1, 4'b1000, 1, 0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 4'b0000, 0, 0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 4'b0000, 0, 0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 4'b0000, 0, 1, 1, 0, 1));
        tbl.push_back(mk(1, 0, 4'b0000, 0, 0, 0, 1, 1));
        tbl.push_back(mk(1, 0, 4'b0000, 0, 0, 0, 0, 1));
        // Back-to-back 1100 then 0011, second LOAD on the last-bit cycle.
        tbl.push_back(mk(0, 1, 4'b1100, 1, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 4'b0000, 0, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 4'b0000, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 4'b0000, 0, 0, 1, 0, 1));
        tbl.push_back(mk(0, 1, 4'b0011, 1, 0, 1, 1, 0));
        tbl.push_back(mk(0, 0, 4'b0000, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 4'b0000, 0, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 4'b0000, 0, 1, 1, 0, 1));
        tbl.push_back(mk(0, 0, 4'b0000, 0, 0, 0, 1, 1));
        tbl.push_back(mk(0, 0, 4'b0000, 0, 0, 0, 0, 1));
        // Ignored LOAD of 1111 while a 0101 frame is mid-flight.
        tbl.push_back(mk(0, 1, 4'b0101, 1, 0, 1, 0, 0));
        tbl.push_back(mk(0, 1, 4'b1111, 0, 1, 1, 0, 0));
        tbl.push_back(mk(0, 1, 4'b1111, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 4'b1111, 0, 1, 1, 0, 1));
        tbl.push_back(mk(0, 0, 4'b0000, 0, 0, 0, 1, 1));
        tbl.push_back(mk(0, 0, 4'b0000, 0, 0, 0, 0, 1));

        // Reset values, applied without any clock edge.
        #1;
        chk("rst_out",   {3'b0, out_m},  4'd0);
        chk("rst_en",    {3'b0, en_m},   4'd0);
        chk("rst_done",  {3'b0, done_m}, 4'd0);
        chk("rst_ready", {3'b0, rdy_m},  4'd1);
        @(negedge clk);
        rst = 1'b0;

        foreach (tbl[i]) apply_row(tbl[i]);

        // Reset mid-frame: two bits of 1010 go out, then RESET aborts the frame.
        q_m.push_back(1'b1);
        q_m.push_back(1'b0);
        load_m = 1'b1; din_m = 4'b1010; load_l = 1'b0;
        @(posedge clk); #1;
        chk("mr_bit0", {3'b0, out_m}, 4'd1);
        load_m = 1'b0;
        @(posedge clk); #1;
        chk("mr_bit1", {3'b0, out_m}, 4'd0);
        #2;
        rst = 1'b1;
        #1;
        chk("mr_async_out", {3'b0, out_m}, 4'd0);
        chk("mr_async_en",  {3'b0, en_m},  4'd0);
        chk("mr_async_rdy", {3'b0, rdy_m}, 4'd1);
        @(posedge clk); #1;
        chk("mr_no_done", {3'b0, done_m}, 4'd0);
        @(negedge clk);
        rst = 1'b0;
        apply_row(mk(0, 1, 4'b0110, 1, 0, 1, 0, 0));
        apply_row(mk(0, 0, 4'b0000, 0, 1, 1, 0, 0));
        apply_row(mk(0, 0, 4'b0000, 0, 1, 1, 0, 0));
        apply_row(mk(0, 0, 4'b0000, 0, 0, 1, 0, 1));
        apply_row(mk(0, 0, 4'b0000, 0, 0, 0, 1, 1));
        apply_row(mk(0, 0, 4'b0000, 0, 0, 0, 0, 1));

        repeat (2) @(posedge clk);
        #3;
        chk("sb_m_left", q_m.size(), 4'd0);
        chk("sb_l_left", q_l.size(), 4'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
